// File: rtl/mfe_window_fetch.sv
// Median filter engine fetch stage: raster-walks the image ROM and emits the
// zero-padded 3x3 window of every pixel, reusing two columns between windows.
module mfe_window_fetch #(
   parameter int DW    = 8,
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ready,
   output logic            busy,
   output logic [AW-1:0]   iaddr,
   input  logic [DW-1:0]   idata,
   output logic            win_valid,
   input  logic            win_ready,
   output logic [9*DW-1:0] win_data,
   output logic [AW-1:0]   win_addr
);
   // One spare bit so the look-ahead column x+1 never wraps at the right edge.
   localparam int XW = $clog2(IMG_W) + 1;
   localparam int YW = $clog2(IMG_H) + 1;

   typedef enum logic [2:0] {IDLE, F0, F1, F2, CAPT, PRESENT} state_t;

   state_t                  state_q;
   logic [XW-1:0]           x_q;
   logic [YW-1:0]           y_q;
   logic                    prime_q;
   logic [DW-1:0]           top_q, mid_q;
   logic [8:0][DW-1:0]      win_q;
   logic [XW-1:0]           col_c;
   logic                    col_pad;
   logic [DW-1:0]           cap_d;

   function automatic logic [AW-1:0] rom_addr(input int r, input int c);
      int rc, cc;
      rc = (r < 0) ? 0 : ((r > IMG_H - 1) ? IMG_H - 1 : r);
      cc = (c > IMG_W - 1) ? IMG_W - 1 : c;
      return AW'(rc * IMG_W + cc);
   endfunction

   assign col_c    = prime_q ? x_q : x_q + 1'b1;
   assign col_pad  = int'(col_c) > IMG_W - 1;
   assign win_data = win_q;

   // Clamped reads still return real pixels; padding is applied on capture.
   always_comb begin
      cap_d = idata;
      if (col_pad)
         cap_d = '0;
      else if (state_q == F1 && y_q == '0)
         cap_d = '0;
      else if (state_q == CAPT && int'(y_q) == IMG_H - 1)
         cap_d = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         busy      <= 1'b0;
         iaddr     <= '0;
         win_valid <= 1'b0;
         win_addr  <= '0;
         win_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         prime_q   <= 1'b0;
         top_q     <= '0;
         mid_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (ready) begin
               busy    <= 1'b1;
               x_q     <= '0;
               y_q     <= '0;
               prime_q <= 1'b1;
               win_q   <= '0;
               iaddr   <= rom_addr(-1, 0);
               state_q <= F0;
            end
            F0: begin
               iaddr   <= rom_addr(int'(y_q), int'(col_c));
               state_q <= F1;
            end
            F1: begin
               top_q   <= cap_d;
               iaddr   <= rom_addr(int'(y_q) + 1, int'(col_c));
               state_q <= F2;
            end
            F2: begin
               mid_q   <= cap_d;
               state_q <= CAPT;
            end
            CAPT: begin
               // Shift left one column; the new column lands in p2/p5/p8.
               win_q <= {cap_d, win_q[8:7], mid_q, win_q[5:4], top_q, win_q[2:1]};
               if (prime_q) begin
                  prime_q <= 1'b0;
                  iaddr   <= rom_addr(int'(y_q) - 1, int'(x_q) + 1);
                  state_q <= F0;
               end else begin
                  win_valid <= 1'b1;
                  win_addr  <= AW'(int'(y_q) * IMG_W + int'(x_q));
                  state_q   <= PRESENT;
               end
            end
            PRESENT: if (win_ready) begin
               win_valid <= 1'b0;
               if (int'(x_q) < IMG_W - 1) begin
                  x_q     <= x_q + 1'b1;
                  iaddr   <= rom_addr(int'(y_q) - 1, int'(x_q) + 2);
                  state_q <= F0;
               end else if (int'(y_q) < IMG_H - 1) begin
                  // Cleared window stands in for the padded column left of x=0.
                  x_q     <= '0;
                  y_q     <= y_q + 1'b1;
                  win_q   <= '0;
                  prime_q <= 1'b1;
                  iaddr   <= rom_addr(int'(y_q), 0);
                  state_q <= F0;
               end else begin
                  busy    <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mfe_window_fetch.sv
// Scoreboard bench for mfe_window_fetch: expected windows are queued at frame
// start and popped by an independent monitor on every handshake.
module tb_mfe_window_fetch;
   localparam int DW    = 8;
   localparam int IMG_W = 128;
   localparam int IMG_H = 128;
   localparam int AW    = 14;
   localparam int NPIX  = IMG_W * IMG_H;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            ready = 1'b0;
   logic            win_ready = 1'b1;
   logic            busy, win_valid;
   logic [AW-1:0]   iaddr, win_addr;
   logic [DW-1:0]   idata = '0;
   logic [9*DW-1:0] win_data;

   mfe_window_fetch #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
      .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr),
      .idata(idata), .win_valid(win_valid), .win_ready(win_ready),
      .win_data(win_data), .win_addr(win_addr)
   );

   always #5 clk = ~clk;

   // Synchronous ROM, pix(r,c) = (r*128+c) & 0xFF
   always @(posedge clk) idata <= iaddr[7:0];

   typedef struct {
      logic [AW-1:0]   addr;
      logic [9*DW-1:0] data;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [9*DW-1:0] model(input int a);
      logic [9*DW-1:0] w;
      int y, x, r, c;
      w = '0;
      y = a / IMG_W;
      x = a % IMG_W;
      for (int dr = -1; dr <= 1; dr++)
         for (int dc = -1; dc <= 1; dc++) begin
            r = y + dr;
            c = x + dc;
            if (r >= 0 && r < IMG_H && c >= 0 && c < IMG_W)
               w[((dr + 1) * 3 + (dc + 1)) * DW +: DW] = DW'((r * IMG_W + c) & 255);
         end
      return w;
   endfunction

   // p8 is the most significant byte
   function automatic logic [9*DW-1:0] expect_win(input int a);
      case (a)
         0:       return 72'h81_80_00_01_00_00_00_00_00;
         5:       return 72'h86_85_84_06_05_04_00_00_00;
         129:     return 72'h02_01_00_82_81_80_02_01_00;
         16383:   return 72'h00_00_00_00_FF_FE_00_7F_7E;
         default: return model(a);
      endcase
   endfunction

   task automatic push_frame();
      exp_t e;
      for (int a = 0; a < NPIX; a++) begin
         e.addr = AW'(a);
         e.data = expect_win(a);
         exp_q.push_back(e);
      end
   endtask

   // Monitor
   int t0 = 0, hs_cnt = 0, last_hs = 0, stall_cnt = 0, t_fall = 0;
   bit first_v = 0, prev_busy = 0, frame_done = 0;

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
         if (busy && !prev_busy) begin
            t0 = cyc; hs_cnt = 0; first_v = 0; stall_cnt = 0; frame_done = 0;
         end
         if (win_valid && !first_v) begin
            first_v = 1;
            chk("first_valid_latency", cyc - t0, 8);
         end
         if (win_valid && !win_ready) begin
            stall_cnt++;
            chk("stall_addr", win_addr, 5);
            chk("stall_iaddr", iaddr, 134);
            chk("stall_data", win_data, 72'h86_85_84_06_05_04_00_00_00);
         end
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) chk("sb_empty", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("win_addr", win_addr, e.addr);
               chk("win_data", win_data, e.data);
            end
            if (hs_cnt > 0)
               chk("hs_interval", cyc - last_hs, ((win_addr % IMG_W) == 0 ? 9 : 5) + stall_cnt);
            last_hs = cyc; hs_cnt++; stall_cnt = 0;
         end
         if (!busy && prev_busy) begin
            t_fall = cyc; frame_done = 1;
         end
      end
      prev_busy = busy;
   end

   task automatic wait_addr(input int a);
      bit hit;
      hit = 0;
      for (int k = 0; k < 5000 && !hit; k++) begin
         @(posedge clk); #1;
         if (win_valid && win_addr == AW'(a)) hit = 1;
      end
      if (!hit) chk("wait_addr_timeout", 0, 1);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_iaddr"}, iaddr, 0);
      chk({tag, "_win_valid"}, win_valid, 0);
      chk({tag, "_win_data"}, win_data, 0);
      chk({tag, "_win_addr"}, win_addr, 0);
   endtask

   task automatic start_frame();
      push_frame();
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      chk("busy_rise", busy, 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset");
      reset = 1'b1;
      @(posedge clk); #1;

      // Frame A: stall at window 5, then abort with reset mid-row 3
      start_frame();
      wait_addr(5);
      win_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      win_ready = 1'b1;
      wait_addr(3 * IMG_W + 10);
      #2;
      reset = 1'b0;
      #1;
      check_zero_outputs("midreset");
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk); #1;

      // Frame B: full frame, ready toggled while busy
      start_frame();
      for (int k = 0; k < 90000 && !frame_done; k++) begin
         @(posedge clk); #1;
         ready = (k < 80000) && (k % 37 == 0);
      end
      ready = 1'b0;
      chk("frame_done", frame_done, 1);
      chk("frame_cycles", t_fall - t0, 82432);
      chk("handshakes", hs_cnt, NPIX);
      chk("sb_leftover", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("end_busy", busy, 0);
      chk("end_valid", win_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
